// File: rtl/seg7_scan_decoder_if.sv
// Pin-side bundle for the 7-segment loopback decoder.
// Handshake: there is no backpressure. The monitor side (slave) watches the
// display pins continuously; frame_valid and bad_pattern are single-cycle
// valid pulses with an implicit, always-asserted ready on the consumer side,
// and digits_out/digit_valid/err_sticky are level outputs that only change
// on an acceptance edge (or on clr_err / reset).
interface seg7_scan_decoder_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              seg_in;
    logic [NUM_DIGITS-1:0]   an_in;
    logic                    clr_err;
    logic [4*NUM_DIGITS-1:0] digits_out;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic                    frame_valid;
    logic                    bad_pattern;
    logic                    err_sticky;

    modport master (
        output seg_in, an_in, clr_err,
        input  digits_out, digit_valid, frame_valid, bad_pattern, err_sticky
    );

    modport slave (
        input  seg_in, an_in, clr_err,
        output digits_out, digit_valid, frame_valid, bad_pattern, err_sticky
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Receive-side decoder for a multiplexed active-low common-anode 7-segment
// bus. Synchronizes the pins, waits for a pattern to hold steady for
// STABLE_CYCLES samples, then converts it back into a hex nibble per digit.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input logic              clk,
    input logic              rst,
    seg7_scan_decoder_if.slave bus
);
    localparam int W  = NUM_DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ACC = CW'(STABLE_CYCLES - 1);

    // Synchronizer stages and the previous sample; all-ones means no digit driven.
    logic [W-1:0] sync1, sync2, prev_s;
    logic [CW-1:0] cnt, cnt_next;
    logic same, accept;

    logic [NUM_DIGITS-1:0]   an, sel;
    logic [6:0]              seg;
    logic                    none_low, one_low;
    logic [4:0]              glyph;

    logic [4*NUM_DIGITS-1:0] digits_q, digits_n;
    logic [NUM_DIGITS-1:0]   valid_q, valid_n;
    logic [NUM_DIGITS-1:0]   seen_q, seen_n, mark;
    logic                    frame_q, frame_n;
    logic                    bad_q, bad_n;
    logic                    err_q, err_n;

    // Legal glyph table: {legal, nibble}; anything else returns legal=0.
    function automatic logic [4:0] glyph_decode(input logic [6:0] s);
        case (s)
            7'h40:   glyph_decode = {1'b1, 4'h0};
            7'h79:   glyph_decode = {1'b1, 4'h1};
            7'h24:   glyph_decode = {1'b1, 4'h2};
            7'h30:   glyph_decode = {1'b1, 4'h3};
            7'h19:   glyph_decode = {1'b1, 4'h4};
            7'h12:   glyph_decode = {1'b1, 4'h5};
            7'h02:   glyph_decode = {1'b1, 4'h6};
            7'h78:   glyph_decode = {1'b1, 4'h7};
            7'h00:   glyph_decode = {1'b1, 4'h8};
            7'h10:   glyph_decode = {1'b1, 4'h9};
            7'h08:   glyph_decode = {1'b1, 4'hA};
            7'h03:   glyph_decode = {1'b1, 4'hB};
            7'h46:   glyph_decode = {1'b1, 4'hC};
            7'h21:   glyph_decode = {1'b1, 4'hD};
            7'h06:   glyph_decode = {1'b1, 4'hE};
            7'h0E:   glyph_decode = {1'b1, 4'hF};
            default: glyph_decode = 5'h00;
        endcase
    endfunction

    // Two-flop synchronizer plus the one-sample history used for stability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= '1;
            sync2  <= '1;
            prev_s <= '1;
        end else begin
            sync1  <= {bus.an_in, bus.seg_in};
            sync2  <= sync1;
            prev_s <= sync2;
        end
    end

    // Stability counter: reload on change, saturate at STABLE_CYCLES, and
    // accept exactly on the step that lands on STABLE_CYCLES.
    always_comb begin
        same     = (sync2 == prev_s);
        cnt_next = cnt;
        if (!same) begin
            cnt_next = CW'(1);
        end else if (cnt != CNT_MAX) begin
            cnt_next = cnt + CW'(1);
        end
        accept = same && (cnt == CNT_ACC);
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    // Anode classification and glyph lookup of the current sample.
    always_comb begin
        an       = sync2[W-1:7];
        seg      = sync2[6:0];
        sel      = ~an;
        none_low = (sel == '0);
        one_low  = !none_low && ((sel & (sel - NUM_DIGITS'(1))) == '0);
        glyph    = glyph_decode(seg);
    end

    // Next output state: slot write / blank / error, seen mask and frame.
    always_comb begin
        digits_n = digits_q;
        valid_n  = valid_q;
        mark     = '0;
        frame_n  = 1'b0;
        bad_n    = 1'b0;
        if (accept && !none_low) begin
            if (!one_low) begin
                bad_n = 1'b1;
            end else if (glyph[4]) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel[i]) begin
                        digits_n[4*i +: 4] = glyph[3:0];
                    end
                end
                valid_n = valid_q | sel;
                mark    = sel;
            end else if (seg == 7'h7F) begin
                valid_n = valid_q & ~sel;
                mark    = sel;
            end else begin
                bad_n = 1'b1;
            end
        end
        seen_n = seen_q | mark;
        if ((mark != '0) && (&seen_n)) begin
            frame_n = 1'b1;
            seen_n  = '0;
        end
        // A new error beats a simultaneous clear.
        if (bad_n) begin
            err_n = 1'b1;
        end else if (bus.clr_err) begin
            err_n = 1'b0;
        end else begin
            err_n = err_q;
        end
    end

    // Registered outputs and seen mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_q <= '0;
            valid_q  <= '0;
            seen_q   <= '0;
            frame_q  <= 1'b0;
            bad_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            digits_q <= digits_n;
            valid_q  <= valid_n;
            seen_q   <= seen_n;
            frame_q  <= frame_n;
            bad_q    <= bad_n;
            err_q    <= err_n;
        end
    end

    assign bus.digits_out  = digits_q;
    assign bus.digit_valid = valid_q;
    assign bus.frame_valid = frame_q;
    assign bus.bad_pattern = bad_q;
    assign bus.err_sticky  = err_q;
endmodule
